// File: rtl/encoder_stream_pkg.sv
// Shared types and width helpers for the mask-to-index stream encoder.
package encoder_stream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int calc_iw(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int calc_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/encoder_pe_core.sv
// Combinational priority selector: any-bit flag, selected index and its one-hot.
module encoder_pe_core
    import encoder_stream_pkg::*;
#(
    parameter int N = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IW = calc_iw(N)
) (
    input  logic [N-1:0]  mask_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    localparam int LG = IW;
    localparam int P = 1 << LG;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    genvar l, j;

    // Balanced pairwise tree over a power-of-two padded mask; pads never win.
    for (l = 0; l <= LG; l++) begin : g_lvl
        logic          v  [P >> l];
        logic [IW-1:0] ix [P >> l];

        if (l == 0) begin : g_leaf
            for (j = 0; j < P; j++) begin : g_n
                if (j < N) begin : g_in
                    assign v[j] = mask_i[j];
                end else begin : g_pad
                    assign v[j] = 1'b0;
                end
                assign ix[j] = IW'(j);
            end
        end else begin : g_node
            for (j = 0; j < (P >> l); j++) begin : g_n
                logic          lo_v, hi_v;
                logic [IW-1:0] lo_ix, hi_ix;

                assign lo_v  = g_lvl[l-1].v[2*j];
                assign hi_v  = g_lvl[l-1].v[2*j+1];
                assign lo_ix = g_lvl[l-1].ix[2*j];
                assign hi_ix = g_lvl[l-1].ix[2*j+1];
                assign v[j]  = lo_v | hi_v;

                if (MSB_FIRST) begin : g_hi
                    assign ix[j] = hi_v ? hi_ix : lo_ix;
                end else begin : g_lo
                    assign ix[j] = lo_v ? lo_ix : hi_ix;
                end
            end
        end
    end

    assign any_o    = g_lvl[LG].v[0];
    assign idx_o    = g_lvl[LG].ix[0];
    assign onehot_o = any_o ? (ONE << idx_o) : '0;

endmodule

// File: rtl/encoder_stream.sv
// Drains an N-bit mask into a stream of set-bit indices with last/empty/seq sidebands.
module encoder_stream
    import encoder_stream_pkg::*;
#(
    parameter int N = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IW = calc_iw(N),
    localparam int CW = calc_cw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [N-1:0]  s_mask,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [IW-1:0] m_index,
    output logic          m_last,
    output logic          m_empty,
    output logic [CW-1:0] m_seq,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [N-1:0]  work_q, work_d;
    logic [CW-1:0] seq_q, seq_d;
    logic          empty_q, empty_d;

    logic          any;
    logic [IW-1:0] sel_idx;
    logic [N-1:0]  sel_oh;
    logic          drain;
    logic          last_beat;
    logic          fire;

    encoder_pe_core #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_pe (
        .mask_i   (work_q),
        .any_o    (any),
        .idx_o    (sel_idx),
        .onehot_o (sel_oh)
    );

    assign drain     = (state_q == DRAIN);
    assign last_beat = empty_q | ((work_q & ~sel_oh) == '0);
    assign fire      = drain & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            seq_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            seq_q   <= seq_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (s_valid) state_d = DRAIN;
            DRAIN:   if (m_ready && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_d  = work_q;
        seq_d   = seq_q;
        empty_d = empty_q;
        if (!drain && s_valid) begin
            work_d  = s_mask;
            seq_d   = '0;
            empty_d = (s_mask == '0);
        end else if (fire) begin
            work_d = work_q & ~sel_oh;
            seq_d  = seq_q + 1'b1;
        end
    end

    // Sidebands are forced to zero outside DRAIN so stale seq/empty never leak.
    always_comb begin
        s_ready = ~drain;
        m_valid = drain;
        busy    = drain;
        m_index = (drain && any) ? sel_idx : '0;
        m_last  = drain & last_beat;
        m_empty = drain & empty_q;
        m_seq   = drain ? seq_q : '0;
    end

endmodule

// File: tb/tb_encoder_stream.sv
// Scoreboard bench: three encoder_stream instances driven in lockstep, random and directed masks.
module tb_encoder_stream;

    typedef struct {
        int idx;
        bit last;
        bit empty;
        int seq;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_mask;
    logic       m_ready;

    logic       s_ready_a, m_valid_a, m_last_a, m_empty_a, busy_a;
    logic [2:0] m_index_a;
    logic [3:0] m_seq_a;
    logic       s_ready_b, m_valid_b, m_last_b, m_empty_b, busy_b;
    logic [2:0] m_index_b;
    logic [3:0] m_seq_b;
    logic       s_ready_c, m_valid_c, m_last_c, m_empty_c, busy_c;
    logic [2:0] m_index_c;
    logic [2:0] m_seq_c;

    int      checks = 0;
    int      errors = 0;
    int      rmode  = 0;
    beat_t   qa[$];
    beat_t   qb[$];
    beat_t   qc[$];

    encoder_stream #(.N(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_mask(s_mask), .m_valid(m_valid_a), .m_ready(m_ready),
        .m_index(m_index_a), .m_last(m_last_a), .m_empty(m_empty_a),
        .m_seq(m_seq_a), .busy(busy_a)
    );

    encoder_stream #(.N(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_mask(s_mask), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_index(m_index_b), .m_last(m_last_b), .m_empty(m_empty_b),
        .m_seq(m_seq_b), .busy(busy_b)
    );

    encoder_stream #(.N(5), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_c),
        .s_mask(s_mask[4:0]), .m_valid(m_valid_c), .m_ready(m_ready),
        .m_index(m_index_c), .m_last(m_last_c), .m_empty(m_empty_c),
        .m_seq(m_seq_c), .busy(busy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: list set bits, order them, tag the final one; zero mask is one empty beat.
    function automatic beat_q_t gen(input int n, input bit msb, input logic [7:0] m);
        beat_q_t r;
        int      ids[$];
        beat_t   b;
        for (int i = 0; i < n; i++)
            if (m[i]) ids.push_back(i);
        if (msb) ids.reverse();
        if (ids.size() == 0) begin
            b.idx = 0; b.last = 1'b1; b.empty = 1'b1; b.seq = 0;
            r.push_back(b);
        end else begin
            for (int k = 0; k < ids.size(); k++) begin
                b.idx   = ids[k];
                b.last  = (k == ids.size() - 1);
                b.empty = 1'b0;
                b.seq   = k;
                r.push_back(b);
            end
        end
        return r;
    endfunction

    function automatic int popc(input logic [7:0] m);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m[i]);
        return c;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic cmp(input string nm, input beat_t e, input int idx,
                       input bit last, input bit empty, input int seq);
        checks++;
        if (e.idx != idx || e.last != last || e.empty != empty || e.seq != seq) begin
            errors++;
            $display("FAIL %s beat: got idx=%0d last=%0d empty=%0d seq=%0d want idx=%0d last=%0d empty=%0d seq=%0d",
                     nm, idx, last, empty, seq, e.idx, e.last, e.empty, e.seq);
        end
    endtask

    initial begin
        int pc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (pc % 4 == 0) || (pc % 4 == 3);
                    pc++;
                end
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid_a && m_ready) begin
            if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
            else cmp("a", qa.pop_front(), m_index_a, m_last_a, m_empty_a, m_seq_a);
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid_b && m_ready) begin
            if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
            else cmp("b", qb.pop_front(), m_index_b, m_last_b, m_empty_b, m_seq_b);
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid_c && m_ready) begin
            checks++;
            if (m_index_c > 3'd4) begin
                errors++;
                $display("FAIL c_idx_range: got %0d want <= 4", m_index_c);
            end
            if (qc.size() == 0) chk("c_unexpected_beat", 1, 0);
            else cmp("c", qc.pop_front(), m_index_c, m_last_c, m_empty_c, m_seq_c);
        end
    end

    // Held beat must not change while stalled.
    always @(negedge clk) begin
        static bit   stall_p = 1'b0;
        static int   idx_p, seq_p;
        static bit   last_p, empty_p;
        if (!rst && stall_p && m_valid_a) begin
            chk("a_stall_idx", m_index_a, idx_p);
            chk("a_stall_seq", m_seq_a, seq_p);
            chk("a_stall_last", m_last_a, last_p);
            chk("a_stall_empty", m_empty_a, empty_p);
        end
        stall_p = !rst && m_valid_a && !m_ready;
        idx_p   = m_index_a;
        seq_p   = m_seq_a;
        last_p  = m_last_a;
        empty_p = m_empty_a;
    end

    task automatic wait_idle();
        int t = 0;
        while (!(s_ready_a && s_ready_b && s_ready_c) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) chk("idle_timeout", t, 0);
    endtask

    task automatic push_all(input logic [7:0] m);
        beat_q_t t;
        t = gen(8, 1'b1, m);
        foreach (t[i]) qa.push_back(t[i]);
        t = gen(8, 1'b0, m);
        foreach (t[i]) qb.push_back(t[i]);
        t = gen(5, 1'b1, {3'b000, m[4:0]});
        foreach (t[i]) qc.push_back(t[i]);
    endtask

    task automatic send(input logic [7:0] m, input bit chk_busy);
        int c = 0;
        wait_idle();
        s_valid = 1'b1;
        s_mask  = m;
        push_all(m);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_mask  = 8'($urandom);
        if (chk_busy) begin
            while (!s_ready_a && c < 100) begin
                c++;
                @(posedge clk);
                #1;
            end
            chk("a_busy_cycles", c, (popc(m) == 0) ? 1 : popc(m));
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_mask  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready_a, 1);
        chk("rst_m_valid", m_valid_a, 0);
        chk("rst_m_index", m_index_a, 0);
        chk("rst_m_last", m_last_a, 0);
        chk("rst_m_empty", m_empty_a, 0);
        chk("rst_m_seq", m_seq_a, 0);
        chk("rst_busy", busy_a, 0);
        rst = 1'b0;

        send(8'hA5, 1'b1);
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        send(8'h1F, 1'b1);

        wait_idle();
        rmode = 1;
        send(8'hFF, 1'b0);
        wait_idle();
        rmode = 0;

        send(8'hF0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        chk("midrst_m_valid", m_valid_a, 0);
        chk("midrst_s_ready", s_ready_a, 1);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_b_m_valid", m_valid_b, 0);
        send(8'h02, 1'b1);

        wait_idle();
        rmode = 2;
        repeat (80) begin
            logic [7:0] m;
            m = 8'($urandom);
            if ($urandom_range(0, 7) == 0) m = 8'h00;
            send(m, 1'b0);
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
